// File: rtl/pixel_clock_manager_pkg.sv
// Shared types and constants for the VGA pixel-clock manager.
package vga_clk_pkg;

  localparam int unsigned CLK_DIV_WIDTH = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    PEND   = 2'd3
  } pcm_state_t;

endpackage

// File: rtl/pixel_clock_manager_if.sv
// Divisor-request handshake between a programming master and the pixel-clock manager.
interface pixel_clock_manager_if
  import vga_clk_pkg::*;
#(
  parameter int unsigned WIDTH = CLK_DIV_WIDTH
);

  logic             div_valid;
  logic [WIDTH-1:0] div_value;
  logic             div_ready;
  logic             div_err;

  modport master (output div_valid, div_value, input div_ready, div_err);
  modport slave  (input div_valid, div_value, output div_ready, div_err);

endinterface

// File: rtl/pixel_clock_manager_div_counter.sv
// Period counter: wraps at div-1, flags the terminal cycle and decodes the square wave.
module div_counter
  import vga_clk_pkg::*;
#(
  parameter int unsigned WIDTH = CLK_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] div,
  output logic             terminal,
  output logic             divided_clk
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // div is never 0, so div-1 cannot wrap.
  assign terminal    = (cnt_q == (div - WIDTH'(1)));
  assign divided_clk = (cnt_q >= (div >> 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = terminal ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_clock_manager.sv
// Pixel-clock controller: owns the active divisor, applies changes at period boundaries
// and raises locked after a settle interval.
module pixel_clock_manager
  import vga_clk_pkg::*;
#(
  parameter int unsigned WIDTH           = CLK_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIVISOR = 2,
  parameter int unsigned SETTLE_PERIODS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  pixel_clock_manager_if.slave  bus,
  output logic                  divided_clk,
  output logic                  pix_en,
  output logic                  locked
);

  localparam int unsigned SW = $clog2(SETTLE_PERIODS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_PERIODS - 1);

  pcm_state_t       state_q, state_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             div_err_q, div_err_d;
  logic             cnt_run, cnt_clear, terminal;
  logic             xfer, zero_req;

  assign bus.div_ready = (state_q == IDLE) || (state_q == RUN);
  assign bus.div_err   = div_err_q;
  assign pix_en        = (state_q != IDLE) && terminal;
  assign locked        = (state_q == RUN) || (state_q == PEND);
  assign xfer          = bus.div_valid && bus.div_ready;
  assign zero_req      = (bus.div_value == '0);

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    settle_d   = settle_q;
    div_err_d  = xfer && zero_req;
    cnt_run    = 1'b0;
    cnt_clear  = 1'b0;
    // Dropping enable overrides everything, including a pending swap.
    if (!enable) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
      settle_d  = '0;
      if (xfer && !zero_req) cur_div_d = bus.div_value;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_clear = 1'b1;
          settle_d  = '0;
          state_d   = SETTLE;
          if (xfer && !zero_req) cur_div_d = bus.div_value;
        end
        SETTLE: begin
          cnt_run = 1'b1;
          if (terminal) begin
            settle_d = settle_q + SW'(1);
            if (settle_q == SETTLE_LAST) state_d = RUN;
          end
        end
        RUN: begin
          cnt_run = 1'b1;
          if (xfer && !zero_req && (bus.div_value != cur_div_q)) begin
            pend_div_d = bus.div_value;
            state_d    = PEND;
          end
        end
        PEND: begin
          cnt_run = 1'b1;
          if (terminal) begin
            cur_div_d = pend_div_q;
            cnt_clear = 1'b1;
            settle_d  = '0;
            state_d   = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_div_q  <= WIDTH'(DEFAULT_DIVISOR);
      pend_div_q <= '0;
      settle_q   <= '0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      settle_q   <= settle_d;
      div_err_q  <= div_err_d;
    end
  end

  div_counter #(
    .WIDTH (WIDTH)
  ) u_div_counter (
    .clk         (clk),
    .rst         (rst),
    .run         (cnt_run),
    .clear       (cnt_clear),
    .div         (cur_div_q),
    .terminal    (terminal),
    .divided_clk (divided_clk)
  );

endmodule
